// File: rtl/tdm_pkg.sv
// Shared types and helpers for the 2:1 TDM receive path.
package tdm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic SLOT_A = 1'b0;
   localparam logic SLOT_B = 1'b1;

   // Ceiling log2 with a floor of one bit so a 2-slot frame still gets a counter bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((32'sd1 << i) < n) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/deser_shift.sv
// MSB-first shift register for one channel; exposes its next value so the
// owner can capture a word completing on the same edge.
module deser_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             shift,
   input  logic             din,
   output logic [WIDTH-1:0] word_d
);

   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] shifted_s;

   generate
      if (WIDTH == 1) begin : g_one
         assign shifted_s = din;
      end else begin : g_many
         assign shifted_s = {word_q[WIDTH-2:0], din};
      end
   endgenerate

   // Clear takes priority; clear plus shift starts a fresh word with din.
   always_comb begin
      word_d = word_q;
      if (clr) begin
         if (shift) begin
            word_d = {{(WIDTH-1){1'b0}}, din};
         end else begin
            word_d = {WIDTH{1'b0}};
         end
      end else if (shift) begin
         word_d = shifted_s;
      end else begin
         word_d = word_q;
      end
   end

   // Shift register state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q <= {WIDTH{1'b0}};
      end else begin
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/tdm_demux_1to2.sv
// Receive side of the 2:1 TDM link: locks to frame sync, splits the
// interleaved stream into A/B words and presents them with a valid pulse.
module tdm_demux_1to2
   import tdm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             fs,
   input  logic             y,
   output logic             se,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] b_q,
   output logic             vld,
   output logic             locked,
   output logic             frame_err
);

   localparam int            CW   = clog2(2 * WIDTH);
   localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_d, b_d;
   logic             vld_q, vld_d;
   logic             err_q, err_d;
   logic             shift_a_s, shift_b_s, clr_s;
   logic [WIDTH-1:0] sr_a_d, sr_b_d;

   deser_shift #(.WIDTH(WIDTH)) u_sr_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr_s),
      .shift  (shift_a_s),
      .din    (y),
      .word_d (sr_a_d)
   );

   deser_shift #(.WIDTH(WIDTH)) u_sr_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr_s),
      .shift  (shift_b_s),
      .din    (y),
      .word_d (sr_b_d)
   );

   // Slot tracking, slip detection and word hand-off.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      vld_d     = 1'b0;
      err_d     = 1'b0;
      shift_a_s = 1'b0;
      shift_b_s = 1'b0;
      clr_s     = 1'b0;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (fs) begin
                  clr_s     = 1'b1;
                  shift_a_s = 1'b1;
                  cnt_d     = ONE;
                  state_d   = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (fs && (cnt_q != {CW{1'b0}})) begin
                  // Slip: restart the frame on this bit.
                  err_d     = 1'b1;
                  clr_s     = 1'b1;
                  shift_a_s = 1'b1;
                  cnt_d     = ONE;
               end else begin
                  if (cnt_q[0] == SLOT_A) begin
                     shift_a_s = 1'b1;
                  end else begin
                     shift_b_s = 1'b1;
                  end
                  if (cnt_q == LAST) begin
                     // A is idle on this slot, so its next value equals the finished word.
                     a_d   = sr_a_d;
                     b_d   = sr_b_d;
                     vld_d = 1'b1;
                     cnt_d = {CW{1'b0}};
                  end else begin
                     cnt_d = cnt_q + ONE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = {CW{1'b0}};
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   assign se        = cnt_q[0];
   assign vld       = vld_q;
   assign frame_err = err_q;
   assign locked    = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux_1to2.sv
// Self-checking bench for tdm_demux_1to2: frame table plus hand-written
// sequences for stall, slip and mid-frame reset.
module tb_tdm_demux_1to2;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n, en, fs, y;
   logic         se, vld, locked, frame_err;
   logic [W-1:0] a_q, b_q;

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];
   logic [W-1:0]   last_a = '0, last_b = '0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_a;
      logic [W-1:0] exp_b;
   } vec_t;
   vec_t vecs[3];

   tdm_demux_1to2 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .fs        (fs),
      .y         (y),
      .se        (se),
      .a_q       (a_q),
      .b_q       (b_q),
      .vld       (vld),
      .locked    (locked),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock with the given inputs; checks pulses and pops the scoreboard on vld.
   task automatic step(input logic e, input logic f, input logic d,
                       input logic exp_vld, input logic exp_err);
      logic [2*W-1:0] ent;
      en = e; fs = f; y = d;
      @(posedge clk);
      #1;
      chk("vld", vld, exp_vld);
      chk("frame_err", frame_err, exp_err);
      if (vld === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: vld with no expected word, a_q=%0h b_q=%0h", a_q, b_q);
         end else begin
            ent = exp_q.pop_front();
            chk("a_q", a_q, ent[2*W-1:W]);
            chk("b_q", b_q, ent[W-1:0]);
            last_a = ent[2*W-1:W];
            last_b = ent[W-1:0];
         end
      end
   endtask

   task automatic stall3();
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
   endtask

   // Full frame; fs on the first bit if requested, optional 3-cycle stalls after bits s1/s2.
   task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic fs_first, input logic exp_err_first,
                             input int s1, input int s2);
      logic bitv;
      exp_q.push_back({a, b});
      for (int i = 0; i < 2 * W; i++) begin
         bitv = (i % 2 == 0) ? a[W-1-i/2] : b[W-1-i/2];
         step(1'b1, (i == 0) && fs_first, bitv, (i == 2 * W - 1),
              (i == 0) && exp_err_first);
         chk("se", se, 32'((i + 1) % 2));
         chk("locked", locked, 1);
         if (i == 0 && exp_err_first) begin
            chk("a_q hold on slip", a_q, last_a);
            chk("b_q hold on slip", b_q, last_b);
         end
         if (i + 1 == s1 || i + 1 == s2) begin
            stall3();
            chk("se in stall", se, 32'((i + 1) % 2));
         end
      end
   endtask

   task automatic send_partial(input int n, input logic fs0);
      for (int i = 0; i < n; i++) begin
         step(1'b1, (i == 0) && fs0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         chk("se partial", se, 32'((i + 1) % 2));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst a_q", a_q, 0);
      chk("rst b_q", b_q, 0);
      chk("rst se", se, 0);
      chk("rst locked", locked, 0);
      rst_n = 1'b1;
      last_a = '0;
      last_b = '0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; fs = 1'b0; y = 1'b0;
      vecs[0] = '{a: 8'hFF, b: 8'h00, exp_a: 8'hFF, exp_b: 8'h00};
      vecs[1] = '{a: 8'h01, b: 8'h80, exp_a: 8'h01, exp_b: 8'h80};
      vecs[2] = '{a: 8'h5A, b: 8'hC3, exp_a: 8'h5A, exp_b: 8'hC3};

      // Reset, then lock on the first frame.
      do_reset();
      send_frame(8'hA5, 8'h3C, 1'b1, 1'b0, -1, -1);

      // Bits before fs are dropped in IDLE.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         chk("idle locked", locked, 0);
         chk("idle se", se, 0);
      end
      send_frame(8'hA5, 8'h3C, 1'b1, 1'b0, -1, -1);

      // en stalls inside a frame.
      do_reset();
      send_frame(8'hA5, 8'h3C, 1'b1, 1'b0, 4, 11);

      // Back-to-back frames from the table, fs only on the first.
      do_reset();
      for (int v = 0; v < 3; v++) begin
         send_frame(vecs[v].a, vecs[v].b, (v == 0), 1'b0, -1, -1);
         chk("table a_q", a_q, vecs[v].exp_a);
         chk("table b_q", b_q, vecs[v].exp_b);
      end

      // Slip at bit 7, then slip on the last slot.
      send_partial(7, 1'b0);
      send_frame(8'h96, 8'h69, 1'b1, 1'b1, -1, -1);
      send_partial(15, 1'b0);
      send_frame(8'h3E, 8'hD1, 1'b1, 1'b1, -1, -1);

      // Mid-frame reset discards the partial frame.
      send_partial(9, 1'b0);
      do_reset();
      chk("post-reset vld", vld, 0);
      send_frame(8'hC7, 8'h28, 1'b1, 1'b0, -1, -1);

      chk("scoreboard empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1to2.md
Name: tdm_demux_1to2

Overview:
- Receive end of the 2:1 time-division serial link driven by the team's 2:1 mux: one serial bit stream `y` carries interleaved bits of channel A and channel B.
- Block locks to a frame-sync strobe and tracks the slot (A/B).
- Deserialises WIDTH bits per channel, MSB first, and presents both words in parallel with a one-cycle valid pulse.
- Sits directly behind the link; feeds channel-word consumers.

Parameters:
WIDTH, 8, bits per channel word; frame length = 2*WIDTH bit slots.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous, active-low reset
en  input  1  bit-enable; `y`/`fs` sampled only when en=1
fs  input  1  frame sync; marks current bit as slot 0 (channel A MSB)
y  input  1  serial interleaved data bit
se  output  1  slot of the next expected bit: 0 = channel A, 1 = channel B
a_q  output  WIDTH  last complete channel A word
b_q  output  WIDTH  last complete channel B word
vld  output  1  one-cycle pulse, a_q/b_q updated this cycle
locked  output  1  1 while in RUN state
frame_err  output  1  one-cycle pulse on sync slip

Behaviour:
- Reset (rst_n=0 at an edge):
  - State IDLE, bit counter 0, both shift registers 0.
  - a_q=0, b_q=0, vld=0, se=0, locked=0, frame_err=0.
  - Reset mid-frame discards all partial data.
- Bit acceptance: a bit is accepted at a rising edge with en=1. With en=0, counter, shift registers and state hold; vld and frame_err are 0.
- Slot mapping:
  - Counter cnt runs 0..2*WIDTH-1.
  - Even cnt is channel A, odd cnt is channel B; se = cnt[0].
  - Within a channel the first bit is the MSB (shift left, y enters the LSB).
- State IDLE:
  - Accepted bits with fs=0 are dropped.
  - Accepted bit with fs=1 is stored as A bit (slot 0), cnt becomes 1, next state RUN, locked=1 from the next cycle.
- State RUN:
  - Each accepted bit shifts into the channel selected by cnt[0]; cnt increments.
  - On the accepted bit with cnt=2*WIDTH-1: at that same edge a_q and b_q load the completed words (including this last B bit), vld=1 for exactly that one cycle, cnt wraps to 0, and the state stays RUN (continuous framing).
  - fs=1 with cnt=0 is the expected alignment: no error.
  - fs=0 with cnt=0 is also accepted: free-running, no error.
- Sync slip: fs=1 accepted in RUN with cnt!=0:
  - frame_err=1 for one cycle.
  - Partial frame is discarded; a_q/b_q keep old values and no vld.
  - The current bit is taken as slot 0 and cnt becomes 1.
  - fs on the last slot (cnt=2*WIDTH-1) is also a slip: that frame is not delivered.
- Latency: a_q/b_q/vld update at the edge that accepts the final B bit; no further delay.
- a_q/b_q hold between vld pulses.
- Boundary conditions:
  - en toggling arbitrarily inside a frame only stretches the frame.
  - WIDTH=1 is legal (frame = 2 bits).

Decomposition:
- Shared package tdm_pkg holds:
  - state enum {IDLE, RUN};
  - slot constants SLOT_A=0, SLOT_B=1;
  - counter width function clog2(2*WIDTH).
- One natural sub-module: deser_shift (WIDTH-bit MSB-first shift register with shift-enable and synchronous clear), instantiated twice, once per channel.

Test Plan:
- Reset then lock, WIDTH=8:
  - Stimulus: rst_n low 2 cycles; en=1; fs=1 on the first bit; stream A=0xA5, B=0x3C interleaved MSB first (bits A7,B7,A6,B6,...).
  - Required: vld one cycle at the 16th accepted bit, a_q=0xA5, b_q=0x3C; se alternates 0,1; locked=1 from cycle 2.
- IDLE drop: 5 accepted bits with fs=0 before fs, then the 0xA5/0x3C frame -> the dropped bits never affect the outputs; the same result as the lock scenario.
- Stall: the same frame with en=0 inserted for 3 cycles after bits 4 and 11 -> identical a_q/b_q, vld delayed by 6 cycles, no vld/frame_err during stalls.
- Back-to-back frames:
  - Stimulus: frames (0xFF,0x00) then (0x01,0x80), fs only on the first.
  - Required: two vld pulses 16 accepted bits apart with the correct words; no frame_err.
- Slip: fs=1 on accepted bit 7 of a frame -> frame_err pulse, no vld, a_q/b_q unchanged; the next 16 bits deliver the frame that started at the slip bit.
- Mid-frame reset: rst_n=0 after 9 bits -> all outputs 0, locked=0; a new fs-aligned frame decodes correctly.
